// File: rtl/mult_accum_pkg.sv
// mult_accum_pkg: shared definitions for the product accumulator stage.
//   - state_e  : FSM state encoding (IDLE / ACCUM / HOLD)
//   - acc_wid(): guard-bit accumulator width derivation, so neighbouring
//                stages can size their buses the same way.
package mult_accum_pkg;

  localparam int DATA_WID_DEF = 16;
  localparam int LEN_B_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // 2^len_b terms of magnitude at most 2^(data_wid-1) fit without wrapping.
  function automatic int acc_wid(input int data_wid, input int len_b);
    return data_wid + len_b;
  endfunction

endpackage

// File: rtl/sat_narrow.sv
// sat_narrow: combinational saturating narrower, IN_WID -> OUT_WID (signed).
//   din_i  : signed wide value
//   dout_o : value clipped to [-2^(OUT_WID-1), 2^(OUT_WID-1)-1]
//   clip_o : 1 when din_i was outside the output range
// Requires IN_WID > OUT_WID.
module sat_narrow #(
  parameter int IN_WID  = 24,
  parameter int OUT_WID = 16
) (
  input  logic [IN_WID-1:0]  din_i,
  output logic [OUT_WID-1:0] dout_o,
  output logic               clip_o
);

  // Value fits iff the bits from the output sign bit upward are all equal.
  logic [IN_WID-OUT_WID:0] hi;

  always_comb begin
    hi     = din_i[IN_WID-1:OUT_WID-1];
    dout_o = din_i[OUT_WID-1:0];
    clip_o = 1'b0;
    if ((hi != '0) && (hi != '1)) begin
      clip_o = 1'b1;
      dout_o = din_i[IN_WID-1] ? {1'b1, {(OUT_WID-1){1'b0}}}
                               : {1'b0, {(OUT_WID-1){1'b1}}};
    end
  end

endmodule

// File: rtl/mult_accum.sv
// mult_accum: accumulates len_m1+1 signed products (one per in_valid cycle)
// into a guard-bit accumulator, then presents one saturated DATA_WID-bit
// result on a valid/ready handshake.
//   clk, reset      : clock, synchronous active-high reset
//   start, len_m1   : begin accumulation of len_m1+1 terms (sampled in IDLE)
//   in_valid,in_data: product stream (signed)
//   out_valid,out_ready,out_data,out_sat : result handshake, clip flag
//   busy            : state is not IDLE
module mult_accum
  import mult_accum_pkg::*;
#(
  parameter int DATA_WID = DATA_WID_DEF,
  parameter int LEN_B    = LEN_B_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [LEN_B-1:0]    len_m1,
  input  logic                in_valid,
  input  logic [DATA_WID-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_WID-1:0] out_data,
  output logic                out_sat,
  output logic                busy
);

  localparam int ACC_WID = acc_wid(DATA_WID, LEN_B);

  state_e              state_q;
  logic [ACC_WID-1:0]  acc_q, acc_d;
  logic [LEN_B-1:0]    cnt_q, len_q;
  logic [DATA_WID-1:0] out_data_q, sat_d;
  logic                out_sat_q, out_valid_q, busy_q, clip_d;

  // Running sum including the current term; the last term's result is
  // saturated directly from this so it lands one cycle after that term.
  always_comb begin
    acc_d = acc_q + {{LEN_B{in_data[DATA_WID-1]}}, in_data};
  end

  sat_narrow #(
    .IN_WID  (ACC_WID),
    .OUT_WID (DATA_WID)
  ) u_sat (
    .din_i  (acc_d),
    .dout_o (sat_d),
    .clip_o (clip_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q   <= len_m1;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == len_q) begin
              out_data_q  <= sat_d;
              out_sat_q   <= clip_d;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mult_accum.sv
module tb_mult_accum;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, out_ready;
  logic [7:0]  len_m1;
  logic [15:0] in_data;
  logic        out_valid, out_sat, busy;
  logic [15:0] out_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult_accum #(
    .DATA_WID (16),
    .LEN_B    (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len_m1    (len_m1),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic chk_res(input string tag, input int d, input logic s);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".data"}, 32'($signed(out_data)), 32'(d));
    chk({tag, ".sat"}, 32'(out_sat), 32'(s));
  endtask

  task automatic begin_acc(input logic [7:0] l);
    start  = 1'b1;
    len_m1 = l;
    tick();
    start  = 1'b0;
  endtask

  task automatic term(input int v);
    in_valid = 1'b1;
    in_data  = 16'(v);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    len_m1 = '0; in_data = '0;
    tick(); tick();
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.data", 32'(out_data), 32'd0);
    chk("rst.sat", 32'(out_sat), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // in_valid in IDLE is ignored
    term(500);
    chk("idle.busy", 32'(busy), 32'd0);

    // Basic sum: 10 - 3 + 7 + 100 = 114; len_m1 changed after start
    begin_acc(8'd3);
    len_m1 = 8'd0;
    chk("basic.busy", 32'(busy), 32'd1);
    term(10); term(-3); term(7);
    chk("basic.early", 32'(out_valid), 32'd0);
    term(100);
    chk_res("basic", 114, 1'b0);
    tick();
    chk("basic.drop", 32'(out_valid), 32'd0);
    chk("basic.idle", 32'(busy), 32'd0);

    // Bubbles: 5 + 6 - 1 = 10
    begin_acc(8'd2);
    term(5); tick(); tick(); term(6); tick();
    chk("bub.early", 32'(out_valid), 32'd0);
    term(-1);
    chk_res("bub", 10, 1'b0);
    tick();
    chk("bub.drop", 32'(out_valid), 32'd0);

    // Positive and negative saturation
    begin_acc(8'd1);
    term(32767); term(32767);
    chk_res("psat", 32767, 1'b1);
    tick();
    begin_acc(8'd1);
    term(-32768); term(-1);
    chk_res("nsat", -32768, 1'b1);
    tick();

    // Backpressure: result 3 held for 5 cycles while inputs toggle
    out_ready = 1'b0;
    begin_acc(8'd1);
    term(1); term(2);
    chk_res("bp0", 3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      start    = i[0];
      in_data  = 16'd1000;
      tick();
      chk_res("bp.hold", 3, 1'b0);
      chk("bp.busy", 32'(busy), 32'd1);
    end
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp.drop", 32'(out_valid), 32'd0);
    chk("bp.idle", 32'(busy), 32'd0);

    // Full length: 256 x 32767 saturates, no wrap; start right after handshake
    begin_acc(8'd255);
    for (int i = 0; i < 255; i++) term(32767);
    chk("full.early", 32'(out_valid), 32'd0);
    term(32767);
    chk_res("full", 32767, 1'b1);
    tick();
    begin_acc(8'd0);
    term(-42);
    chk_res("single", -42, 1'b0);
    tick();

    // Full length negative: 256 x -32768 = -2^23 is the accumulator floor
    begin_acc(8'd255);
    for (int i = 0; i < 256; i++) term(-32768);
    chk_res("fullneg", -32768, 1'b1);
    tick();

    // Reset mid-accumulation discards the partial sum
    begin_acc(8'd3);
    term(50); term(60);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst.valid", 32'(out_valid), 32'd0);
    chk("mrst.data", 32'(out_data), 32'd0);
    chk("mrst.sat", 32'(out_sat), 32'd0);
    chk("mrst.busy", 32'(busy), 32'd0);
    begin_acc(8'd0);
    term(9);
    chk_res("mrst.new", 9, 1'b0);

    // Reset during HOLD drops the pending result
    out_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("hrst.valid", 32'(out_valid), 32'd0);
    chk("hrst.busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
